// File: rtl/segre_mem_stage.sv
// -----------------------------------------------------------------------------
// segre_mem_stage
//
// Memory stage of the Segre in-order pipeline. This stage sits directly after
// execute and holds the EX/MEM and MEM/WB decoupling registers. Each load or
// store performs exactly one data-memory access through a req/rsp handshake.
// While that access is outstanding, EX and every earlier stage are stalled.
// The stage also does byte-lane alignment, byte-enable generation and load
// sign/zero extension.
//
// Optional feature macro: SEGRE_MEM_MISALIGN_EN
//   defined   : a misaligned access (HALF with off[0]=1, or WORD with off!=0)
//               issues no request. It retires as valid_mem_o=1, rf_we_o=0,
//               misalign_o=1.
//   undefined : misalign_o is tied to 0 and the access is aligned down.
//
// Ports
//   clk_i, rsn_i          clock (rising edge), async active-low reset
//   valid_ex_i ...        EX stage instruction fields (alu result / address,
//                         rf write enable + index, store data, memop control,
//                         end-of-test marker)
//   stall_o               holds EX and all earlier stages
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   data-memory request (one cycle)
//   dmem_rsp_valid_i/rdata_i              data-memory response / store ack
//   valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o, finish_test_o
//                         MEM/WB register towards write-back
//   misalign_o            misaligned access flag
// -----------------------------------------------------------------------------
module segre_mem_stage #(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 32,
   parameter int REG_SIZE  = 5
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 valid_ex_i,
   input  logic [WORD_SIZE-1:0] alu_res_i,
   input  logic                 rf_we_i,
   input  logic [REG_SIZE-1:0]  rf_waddr_i,
   input  logic [WORD_SIZE-1:0] rf_st_data_i,
   input  logic [1:0]           memop_type_i,
   input  logic                 memop_rd_i,
   input  logic                 memop_wr_i,
   input  logic                 memop_sign_ext_i,
   input  logic                 finish_test_i,
   output logic                 stall_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [ADDR_SIZE-1:0] dmem_addr_o,
   output logic [3:0]           dmem_be_o,
   output logic [WORD_SIZE-1:0] dmem_wdata_o,
   input  logic                 dmem_rsp_valid_i,
   input  logic [WORD_SIZE-1:0] dmem_rdata_i,
   output logic                 valid_mem_o,
   output logic                 rf_we_o,
   output logic [REG_SIZE-1:0]  rf_waddr_o,
   output logic [WORD_SIZE-1:0] rf_wdata_o,
   output logic                 finish_test_o,
   output logic                 misalign_o
);

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memop_data_type_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   // Shift the addressed lane down to bit 0, then sign- or zero-extend it to
   // the size of the access.
   function automatic logic [WORD_SIZE-1:0] load_extend(
      input logic [WORD_SIZE-1:0] rdata,
      input logic [1:0]           off,
      input memop_data_type_e     dtype,
      input logic                 sext
   );
      logic [WORD_SIZE-1:0] sh;
      logic signed [7:0]    b_s;
      logic signed [15:0]   h_s;
      logic [WORD_SIZE-1:0] res;
      sh  = rdata;
      res = rdata;
      case (dtype)
         BYTE: begin
            sh  = rdata >> {off, 3'b000};
            b_s = $signed(sh[7:0]);
            res = sext ? WORD_SIZE'(b_s) : {{(WORD_SIZE-8){1'b0}}, sh[7:0]};
         end
         HALF: begin
            sh  = rdata >> {off[1], 4'b0000};
            h_s = $signed(sh[15:0]);
            res = sext ? WORD_SIZE'(h_s) : {{(WORD_SIZE-16){1'b0}}, sh[15:0]};
         end
         default: res = rdata;
      endcase
      return res;
   endfunction

   // EX/MEM register contents
   logic                 vld_p0;
   logic                 rd_p0;
   logic                 wr_p0;
   logic                 rf_we_p0;
   logic                 fin_p0;
   logic [WORD_SIZE-1:0] alu_res_p0;
   logic [REG_SIZE-1:0]  waddr_p0;
   logic [WORD_SIZE-1:0] st_data_p0;
   memop_data_type_e     type_p0;
   logic                 sext_p0;

   mem_state_e           state;
   logic                 memop_p0;
   logic                 mis_p0;
   logic                 access_p0;
   logic                 rsp_done;
   logic [1:0]           off;
   logic [WORD_SIZE-1:0] wb_data;

   // ---- EX/MEM boundary -----------------------------------------------------
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         vld_p0   <= 1'b0;
         rd_p0    <= 1'b0;
         wr_p0    <= 1'b0;
         rf_we_p0 <= 1'b0;
         fin_p0   <= 1'b0;
      end else if (!stall_o) begin
         vld_p0   <= valid_ex_i;
         rd_p0    <= memop_rd_i;
         wr_p0    <= memop_wr_i;
         rf_we_p0 <= rf_we_i;
         fin_p0   <= finish_test_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!stall_o) begin
         alu_res_p0 <= alu_res_i;
         waddr_p0   <= rf_waddr_i;
         st_data_p0 <= rf_st_data_i;
         type_p0    <= memop_data_type_e'(memop_type_i);
         sext_p0    <= memop_sign_ext_i;
      end
   end

   assign off      = alu_res_p0[1:0];
   assign memop_p0 = vld_p0 & (rd_p0 | wr_p0);

`ifdef SEGRE_MEM_MISALIGN_EN
   assign mis_p0 = memop_p0 &
                   (((type_p0 == HALF) & off[0]) | ((type_p0 == WORD) & (off != 2'b00)));
`else
   assign mis_p0 = 1'b0;
`endif

   // A misaligned memop never reaches memory. It retires like an ALU op.
   assign access_p0 = memop_p0 & ~mis_p0;
   assign rsp_done  = (state == WAIT) & dmem_rsp_valid_i;

   // Combinational stall. It releases in the response cycle, so the next
   // instruction enters EX/MEM on the same edge that retires this access.
   assign stall_o = access_p0 & ~rsp_done;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (access_p0) state <= WAIT;
            WAIT:    if (dmem_rsp_valid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request side. The request is only qualified by dmem_req_o; all other
   // fields simply follow the EX/MEM register.
   assign dmem_req_o  = (state == IDLE) & access_p0;
   assign dmem_we_o   = wr_p0;
   assign dmem_addr_o = {alu_res_p0[ADDR_SIZE-1:2], 2'b00};

   always_comb begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = st_data_p0;
      case (type_p0)
         BYTE: begin
            dmem_be_o    = 4'b0001 << off;
            dmem_wdata_o = {(WORD_SIZE/8){st_data_p0[7:0]}};
         end
         HALF: begin
            dmem_be_o    = 4'b0011 << {off[1], 1'b0};
            dmem_wdata_o = {(WORD_SIZE/16){st_data_p0[15:0]}};
         end
         default: begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = st_data_p0;
         end
      endcase
   end

   assign wb_data = rd_p0 ? load_extend(dmem_rdata_i, off, type_p0, sext_p0) : alu_res_p0;

   // ---- MEM/WB boundary -----------------------------------------------------
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         valid_mem_o   <= 1'b0;
         rf_we_o       <= 1'b0;
         finish_test_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else if (stall_o) begin
         valid_mem_o   <= 1'b0;
         rf_we_o       <= 1'b0;
         finish_test_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         valid_mem_o   <= vld_p0;
         rf_we_o       <= vld_p0 & rf_we_p0 & ~mis_p0;
         finish_test_o <= fin_p0;
         misalign_o    <= mis_p0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!stall_o) begin
         rf_waddr_o <= waddr_p0;
         rf_wdata_o <= wb_data;
      end
   end

endmodule

// File: tb/tb_segre_mem_stage.sv
module tb_segre_mem_stage;

   logic        clk_i = 1'b0;
   logic        rsn_i;
   logic        valid_ex_i;
   logic [31:0] alu_res_i;
   logic        rf_we_i;
   logic [4:0]  rf_waddr_i;
   logic [31:0] rf_st_data_i;
   logic [1:0]  memop_type_i;
   logic        memop_rd_i;
   logic        memop_wr_i;
   logic        memop_sign_ext_i;
   logic        finish_test_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_rsp_valid_i;
   logic [31:0] dmem_rdata_i;
   logic        valid_mem_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        finish_test_o;
   logic        misalign_o;

   int n_vec = 0;
   int n_err = 0;
   int sc;

   always #5 clk_i = ~clk_i;

   segre_mem_stage dut (
      .clk_i            (clk_i),
      .rsn_i            (rsn_i),
      .valid_ex_i       (valid_ex_i),
      .alu_res_i        (alu_res_i),
      .rf_we_i          (rf_we_i),
      .rf_waddr_i       (rf_waddr_i),
      .rf_st_data_i     (rf_st_data_i),
      .memop_type_i     (memop_type_i),
      .memop_rd_i       (memop_rd_i),
      .memop_wr_i       (memop_wr_i),
      .memop_sign_ext_i (memop_sign_ext_i),
      .finish_test_i    (finish_test_i),
      .stall_o          (stall_o),
      .dmem_req_o       (dmem_req_o),
      .dmem_we_o        (dmem_we_o),
      .dmem_addr_o      (dmem_addr_o),
      .dmem_be_o        (dmem_be_o),
      .dmem_wdata_o     (dmem_wdata_o),
      .dmem_rsp_valid_i (dmem_rsp_valid_i),
      .dmem_rdata_i     (dmem_rdata_i),
      .valid_mem_o      (valid_mem_o),
      .rf_we_o          (rf_we_o),
      .rf_waddr_o       (rf_waddr_o),
      .rf_wdata_o       (rf_wdata_o),
      .finish_test_o    (finish_test_o),
      .misalign_o       (misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_ex;
      valid_ex_i       = 1'b0;
      rf_we_i          = 1'b0;
      memop_rd_i       = 1'b0;
      memop_wr_i       = 1'b0;
      memop_sign_ext_i = 1'b0;
      finish_test_i    = 1'b0;
   endtask

   task automatic set_op(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic sext, input logic [1:0] dtype, input logic we,
                         input logic [4:0] wa, input logic [31:0] sd);
      valid_ex_i       = 1'b1;
      alu_res_i        = addr;
      memop_rd_i       = rd;
      memop_wr_i       = wr;
      memop_sign_ext_i = sext;
      memop_type_i     = dtype;
      rf_we_i          = we;
      rf_waddr_i       = wa;
      rf_st_data_i     = sd;
      finish_test_i    = 1'b0;
   endtask

   // Call this just after the edge that captured the memop. The bench waits
   // wait_cyc extra cycles, then responds for one cycle with rd. On return the
   // result has been clocked into MEM/WB.
   task automatic respond(input int wait_cyc, input logic [31:0] rd, output int stalls);
      stalls = 0;
      for (int i = 0; i <= wait_cyc; i++) begin
         if (stall_o) stalls++;
         tick;
      end
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i     = rd;
      #1;
      chk("stall_drops_on_rsp", stall_o, 1'b0);
      tick;
      dmem_rsp_valid_i = 1'b0;
      dmem_rdata_i     = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rsn_i            = 1'b0;
      alu_res_i        = 32'h0;
      rf_waddr_i       = 5'd0;
      rf_st_data_i     = 32'h0;
      memop_type_i     = 2'd0;
      dmem_rsp_valid_i = 1'b0;
      dmem_rdata_i     = 32'h0;
      clear_ex;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid_mem", valid_mem_o, 1'b0);
      chk("rst_rf_we", rf_we_o, 1'b0);
      chk("rst_finish", finish_test_o, 1'b0);
      chk("rst_misalign", misalign_o, 1'b0);
      chk("rst_req", dmem_req_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      rsn_i = 1'b1;
      tick;

      // ALU op: ADD 0x1234 -> x5, also carries the end-of-test marker
      set_op(32'h0000_1234, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 5'd5, 32'h0);
      finish_test_i = 1'b1;
      tick;
      chk("add_no_req", dmem_req_o, 1'b0);
      chk("add_no_stall", stall_o, 1'b0);
      clear_ex;
      tick;
      chk("add_valid", valid_mem_o, 1'b1);
      chk("add_rf_we", rf_we_o, 1'b1);
      chk("add_waddr", rf_waddr_o, 5'd5);
      chk("add_wdata", rf_wdata_o, 32'h0000_1234);
      chk("add_finish", finish_test_o, 1'b1);
      chk("add_no_req2", dmem_req_o, 1'b0);
      tick;
      chk("bubble_valid", valid_mem_o, 1'b0);

      // LB 0x103 sign-extended, two wait cycles before the response
      set_op(32'h0000_0103, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 5'd6, 32'h0);
      tick;
      chk("lb_req", dmem_req_o, 1'b1);
      chk("lb_addr", dmem_addr_o, 32'h0000_0100);
      chk("lb_be", dmem_be_o, 4'b1000);
      chk("lb_we", dmem_we_o, 1'b0);
      clear_ex;
      respond(2, 32'h80FF_0000, sc);
      chk("lb_stall_cycles", sc, 3);
      chk("lb_wdata", rf_wdata_o, 32'hFFFF_FF80);
      chk("lb_rf_we", rf_we_o, 1'b1);
      chk("lb_waddr", rf_waddr_o, 5'd6);
      chk("lb_valid", valid_mem_o, 1'b1);

      // LHU 0x102, with LW 0x100 waiting behind it in EX
      set_op(32'h0000_0102, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 5'd7, 32'h0);
      tick;
      chk("lhu_req", dmem_req_o, 1'b1);
      chk("lhu_be", dmem_be_o, 4'b1100);
      set_op(32'h0000_0100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd8, 32'h0);
      respond(0, 32'hBEEF_1234, sc);
      chk("lhu_stall_cycles", sc, 1);
      chk("lhu_wdata", rf_wdata_o, 32'h0000_BEEF);
      chk("lhu_waddr", rf_waddr_o, 5'd7);
      chk("lw_b2b_req", dmem_req_o, 1'b1);
      chk("lw_addr", dmem_addr_o, 32'h0000_0100);
      chk("lw_be", dmem_be_o, 4'b1111);
      clear_ex;
      respond(0, 32'hCAFE_F00D, sc);
      chk("lw_wdata", rf_wdata_o, 32'hCAFE_F00D);
      chk("lw_waddr", rf_waddr_o, 5'd8);

      // SB 0xAB to 0x201
      set_op(32'h0000_0201, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'h1234_56AB);
      tick;
      chk("sb_req", dmem_req_o, 1'b1);
      chk("sb_addr", dmem_addr_o, 32'h0000_0200);
      chk("sb_be", dmem_be_o, 4'b0010);
      chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
      chk("sb_we", dmem_we_o, 1'b1);
      clear_ex;
      respond(1, 32'h0, sc);
      chk("sb_valid", valid_mem_o, 1'b1);
      chk("sb_rf_we", rf_we_o, 1'b0);

      // SH 0xBEEF to 0x302: upper half lane, halfword replicated
      set_op(32'h0000_0302, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 32'h0000_BEEF);
      tick;
      chk("sh_be", dmem_be_o, 4'b1100);
      chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
      clear_ex;
      respond(0, 32'h0, sc);

      // LW, then reset in WAIT, then a late response
      set_op(32'h0000_0300, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd9, 32'h0);
      tick;
      chk("rstw_req", dmem_req_o, 1'b1);
      clear_ex;
      tick;
      chk("rstw_wait_noreq", dmem_req_o, 1'b0);
      chk("rstw_wait_stall", stall_o, 1'b1);
      rsn_i = 1'b0;
      #1;
      chk("rstw_req0", dmem_req_o, 1'b0);
      chk("rstw_stall0", stall_o, 1'b0);
      chk("rstw_valid0", valid_mem_o, 1'b0);
      chk("rstw_rf_we0", rf_we_o, 1'b0);
      chk("rstw_misalign0", misalign_o, 1'b0);
      tick;
      rsn_i = 1'b1;
      dmem_rsp_valid_i = 1'b1;
      dmem_rdata_i     = 32'h5555_AAAA;
      #1;
      chk("late_rsp_stall", stall_o, 1'b0);
      chk("late_rsp_req", dmem_req_o, 1'b0);
      tick;
      dmem_rsp_valid_i = 1'b0;
      chk("late_rsp_valid", valid_mem_o, 1'b0);
      chk("late_rsp_rf_we", rf_we_o, 1'b0);
      // A fresh load must request at once, which means the FSM is back in IDLE
      set_op(32'h0000_0400, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd10, 32'h0);
      tick;
      chk("post_rst_req", dmem_req_o, 1'b1);
      clear_ex;
      respond(0, 32'h1122_3344, sc);
      chk("post_rst_wdata", rf_wdata_o, 32'h1122_3344);

      // LW at 0x102
      set_op(32'h0000_0102, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 5'd11, 32'h0);
      tick;
`ifdef SEGRE_MEM_MISALIGN_EN
      chk("mis_no_req", dmem_req_o, 1'b0);
      chk("mis_no_stall", stall_o, 1'b0);
      clear_ex;
      tick;
      chk("mis_flag", misalign_o, 1'b1);
      chk("mis_valid", valid_mem_o, 1'b1);
      chk("mis_rf_we", rf_we_o, 1'b0);
      tick;
      chk("mis_flag_clear", misalign_o, 1'b0);
`else
      chk("aldn_req", dmem_req_o, 1'b1);
      chk("aldn_addr", dmem_addr_o, 32'h0000_0100);
      chk("aldn_be", dmem_be_o, 4'b1111);
      clear_ex;
      respond(0, 32'h0BAD_F00D, sc);
      chk("aldn_wdata", rf_wdata_o, 32'h0BAD_F00D);
      chk("aldn_misalign", misalign_o, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/segre_mem_stage.md
# segre_mem_stage

Memory stage of the Segre in-order pipeline, directly downstream of the execute stage. Owns the EX/MEM and MEM/WB decoupling registers and sequences one data-memory access per load/store through a request/response handshake. Stalls upstream while an access is outstanding. Performs byte-lane alignment, byte-enable generation and load sign/zero extension.

## Interface
- WORD_SIZE, 32, data width.
- ADDR_SIZE, 32, address width.
- REG_SIZE, 5, register-file index width.

- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  asynchronous active-low reset.
- valid_ex_i  in  1  EX holds a valid instruction.
- alu_res_i  in  WORD_SIZE  ALU result, or effective address for memops.
- rf_we_i / rf_waddr_i  in  1 / REG_SIZE  register write enable and destination.
- rf_st_data_i  in  WORD_SIZE  store data.
- memop_type_i  in  2  memop_data_type_e: BYTE=0, HALF=1, WORD=2.
- memop_rd_i / memop_wr_i / memop_sign_ext_i  in  1 each  load, store, sign-extend load.
- finish_test_i  in  1  end-of-test marker.
- stall_o  out  1  hold EX and all earlier stages.
- dmem_req_o  out  1  one-cycle access request.
- dmem_we_o  out  1  access is a store.
- dmem_addr_o  out  ADDR_SIZE  word-aligned address (bits [1:0]=0).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  WORD_SIZE  lane-replicated store data.
- dmem_rsp_valid_i  in  1  response or store acknowledge.
- dmem_rdata_i  in  WORD_SIZE  read word, valid with dmem_rsp_valid_i.
- valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o, finish_test_o  out  1 / 1 / REG_SIZE / WORD_SIZE / 1  MEM/WB register to write-back.
- misalign_o  out  1  misaligned access flagged (see Configuration).

## Operation
- EX/MEM register (q) loads all *_i fields each edge when stall_o=0 and holds them when stall_o=1.
- memop_q = valid_q & (rd_q | wr_q).
- FSM states:
  - IDLE: if memop_q, drive dmem_req_o=1 and go to WAIT.
  - WAIT: dmem_req_o=0. On dmem_rsp_valid_i, go to IDLE.
- stall_o = memop_q & ~(state==WAIT & dmem_rsp_valid_i). This is combinational, so stall_o drops in the response cycle and q accepts the next instruction at that edge.
- dmem_addr_o = {alu_res_q[ADDR_SIZE-1:2], 2'b00}. off = alu_res_q[1:0].
- dmem_be_o:
  - BYTE: 4'b0001<<off.
  - HALF: 4'b0011<<{off[1],1'b0}.
  - WORD: 4'b1111.
- dmem_wdata_o:
  - BYTE: data byte replicated ×4.
  - HALF: data halfword replicated ×2.
  - WORD: as is.
- Load extraction:
  - Shift rdata right by 8·off (BYTE) or 16·off[1] (HALF).
  - Mask to the access size.
  - Sign-extend if sign_ext_q, else zero-extend.
- MEM/WB register updates every edge:
  - Non-memop: captures alu_res_q.
  - Memop completing: captures the extracted load data.
  - stall_o=1: captures a bubble (valid_mem_o=0, rf_we_o=0, finish_test_o=0).
- Stores complete on dmem_rsp_valid_i. Write-back carries rf_we_q, which is 0 for stores.
- dmem_rsp_valid_i in IDLE is ignored.

## Timing
- Reset (async): state=IDLE; valid_q, rd_q, wr_q, rf_we_q, finish_q = 0; all MEM/WB control outputs = 0. Data fields are don't-care.
- Reset outputs: dmem_req_o=0, stall_o=0, misalign_o=0.
- Reset mid-access drops the transaction. Any later response is ignored because the FSM is in IDLE.
- ALU op: captured at edge N, on outputs after edge N+1 (1-cycle stage latency).
- Memop: captured at edge N, request in cycle N..N+1, response earliest in the following cycle, result on outputs after the response edge. Minimum 2 cycles; each extra response-wait cycle adds one.
- Back-to-back memops: the second request issues in the cycle after the first response edge. No idle gap beyond that.
- No new request issues in WAIT. At most one access is outstanding.

## Configuration
- SEGRE_MEM_MISALIGN_EN defined:
  - A misaligned access is HALF with off[0]=1, or WORD with off≠0.
  - No request is issued and stall_o=0.
  - MEM/WB captures valid_mem_o=1, rf_we_o=0, misalign_o=1 for one cycle.
- SEGRE_MEM_MISALIGN_EN undefined:
  - misalign_o is tied to 0.
  - HALF ignores off[0] and WORD ignores off; the access is aligned down.

## Test plan
- ADD result 0x1234 to x5, no memop → after 1 edge: rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, dmem_req_o never set.
- LB addr 0x103, sign_ext=1, rdata 0x80FF_0000 responding 2 cycles after request → rf_wdata_o=0xFFFF_FF80, stall_o high 3 cycles.
- LHU addr 0x102, rdata 0xBEEF_1234 → rf_wdata_o=0x0000_BEEF. LW addr 0x100 immediately after → second dmem_req_o in the cycle after the first response.
- SB 0xAB to addr 0x201 → dmem_addr_o=0x200, dmem_be_o=0010, dmem_wdata_o=0xABABABAB, dmem_we_o=1, rf_we_o=0.
- LW issued, rsn_i pulsed low while in WAIT, late dmem_rsp_valid_i then arrives → all outputs 0, state IDLE, no write-back produced.
- With SEGRE_MEM_MISALIGN_EN: LW addr 0x102 → no dmem_req_o, misalign_o=1 and valid_mem_o=1 for one cycle, rf_we_o=0. Without the macro: request at 0x100 with be=1111.
